// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states and the
// per-pipeline-register control bundle with its flush > stall > bubble priority.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        MULTI,
        DRAIN
    } hz_state_t;

    typedef struct packed {
        logic stall;
        logic flush;
        logic bubble;
    } pipe_ctl_t;

    // A register can only obey one command per cycle: flush wins over stall over bubble.
    function automatic pipe_ctl_t resolve_ctl(input pipe_ctl_t req);
        pipe_ctl_t res;
        res.flush  = req.flush;
        res.stall  = req.stall & ~req.flush;
        res.bubble = req.bubble & ~req.flush & ~req.stall;
        return res;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard sources from the pipeline stages and the per-register control lines
// returned to them. The pipeline side is the master, the sequencer is the slave.
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
);
    logic              imem_busy;
    logic              dmem_busy;
    logic              d_valid;
    logic [REG_AW-1:0] d_rs1;
    logic [REG_AW-1:0] d_rs2;
    logic              d_serialize;
    logic              e_valid;
    logic              m_valid;
    logic              w_valid;
    logic              e_is_load;
    logic [REG_AW-1:0] e_dst;
    logic              e_redirect;
    logic              e_multi_busy;

    logic              stall_pc;
    logic              stall_fd;
    logic              stall_de;
    logic              stall_em;
    logic              stall_mw;
    logic              flush_fd;
    logic              flush_de;
    logic              flush_em;
    logic              bubble_de;
    logic              redirect_take;
    logic [PERF_W-1:0] perf_stall_cnt;
    logic [PERF_W-1:0] perf_flush_cnt;

    modport master (
        output imem_busy, dmem_busy, d_valid, d_rs1, d_rs2, d_serialize,
               e_valid, m_valid, w_valid, e_is_load, e_dst, e_redirect, e_multi_busy,
        input  stall_pc, stall_fd, stall_de, stall_em, stall_mw,
               flush_fd, flush_de, flush_em, bubble_de, redirect_take,
               perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  imem_busy, dmem_busy, d_valid, d_rs1, d_rs2, d_serialize,
               e_valid, m_valid, w_valid, e_is_load, e_dst, e_redirect, e_multi_busy,
        output stall_pc, stall_fd, stall_de, stall_em, stall_mw,
               flush_fd, flush_de, flush_em, bubble_de, redirect_take,
               perf_stall_cnt, perf_flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_loaduse_cmp.sv
// Load-use register match: E destination against either D source, with x0 never a hazard.
module hz_loaduse_cmp #(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_dst,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_match
);

    assign o_match = (i_dst != '0) && ((i_dst == i_rs1) || (i_dst == i_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush/bubble sequencer for the 5-stage pipeline. Outputs are
// combinational from state and hazard inputs; state, pending redirect and counters are registered.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int PERF_W = 32
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave hz
);

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic              r_pend_redirect;
    logic              w_pend_nxt;
    logic              r_lu_done;
    logic              w_lu_fire;
    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    logic      w_lu_match;
    logic      w_drain_busy;
    logic      w_redirect;
    logic      w_serialize;
    logic      w_loaduse;
    logic      w_stall_pc;
    logic      w_stall_fd;
    logic      w_stall_em;
    logic      w_stall_mw;
    logic      w_flush_fd;
    logic      w_flush_em;
    logic      w_redirect_take;
    pipe_ctl_t w_de_req;
    pipe_ctl_t w_de;

    hz_loaduse_cmp #(.REG_AW(REG_AW)) u_loaduse_cmp (
        .i_dst   (hz.e_dst),
        .i_rs1   (hz.d_rs1),
        .i_rs2   (hz.d_rs2),
        .o_match (w_lu_match)
    );

    assign w_drain_busy = hz.e_valid | hz.m_valid | hz.w_valid;
    assign w_redirect   = hz.e_redirect | r_pend_redirect;
    // While draining, D is held, so the held instruction keeps the drain alive.
    assign w_serialize  = hz.d_valid & w_drain_busy & (hz.d_serialize | (r_state == DRAIN));
    // r_lu_done limits the bubble to one cycle per load/consumer pairing.
    assign w_loaduse    = hz.d_valid & hz.e_valid & hz.e_is_load & w_lu_match & ~r_lu_done;

    always_comb begin
        w_stall_pc      = 1'b0;
        w_stall_fd      = 1'b0;
        w_stall_em      = 1'b0;
        w_stall_mw      = 1'b0;
        w_flush_fd      = 1'b0;
        w_flush_em      = 1'b0;
        w_de_req        = '0;
        w_redirect_take = 1'b0;
        w_lu_fire       = 1'b0;
        w_pend_nxt      = r_pend_redirect;
        w_state_nxt     = RUN;
        if (!reset) begin
            w_flush_fd     = 1'b1;
            w_de_req.flush = 1'b1;
            w_flush_em     = 1'b1;
            w_pend_nxt     = 1'b0;
        end else if (hz.dmem_busy) begin
            w_stall_pc     = 1'b1;
            w_stall_fd     = 1'b1;
            w_de_req.stall = 1'b1;
            w_stall_em     = 1'b1;
            w_stall_mw     = 1'b1;
            w_pend_nxt     = r_pend_redirect | hz.e_redirect;
            w_state_nxt    = MEM_WAIT;
        end else if (hz.e_multi_busy) begin
            w_stall_pc     = 1'b1;
            w_stall_fd     = 1'b1;
            w_de_req.stall = 1'b1;
            w_flush_em     = 1'b1;
            w_pend_nxt     = r_pend_redirect | hz.e_redirect;
            w_state_nxt    = MULTI;
        end else if (w_redirect) begin
            // PC loads the target now; a busy fetch is covered by the imem flush below on later cycles.
            w_flush_fd      = 1'b1;
            w_de_req.flush  = 1'b1;
            w_redirect_take = 1'b1;
            w_pend_nxt      = 1'b0;
        end else begin
            if (w_serialize) begin
                w_stall_pc      = 1'b1;
                w_stall_fd      = 1'b1;
                w_de_req.bubble = 1'b1;
                w_state_nxt     = DRAIN;
            end else if (w_loaduse) begin
                w_stall_pc      = 1'b1;
                w_stall_fd      = 1'b1;
                w_de_req.bubble = 1'b1;
                w_lu_fire       = 1'b1;
            end
            if (hz.imem_busy) begin
                w_stall_pc = 1'b1;
                w_flush_fd = ~w_stall_fd;
            end
        end
    end

    assign w_de = resolve_ctl(w_de_req);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state         <= RUN;
            r_pend_redirect <= 1'b0;
            r_lu_done       <= 1'b0;
            r_stall_cnt     <= '0;
            r_flush_cnt     <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_pend_redirect <= w_pend_nxt;
            r_lu_done       <= w_lu_fire;
            if (w_stall_pc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + PERF_W'(1);
            end
            if (w_de.flush && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + PERF_W'(1);
            end
        end
    end

    assign hz.stall_pc       = w_stall_pc;
    assign hz.stall_fd       = w_stall_fd & ~w_flush_fd;
    assign hz.stall_de       = w_de.stall;
    assign hz.stall_em       = w_stall_em & ~w_flush_em;
    assign hz.stall_mw       = w_stall_mw;
    assign hz.flush_fd       = w_flush_fd;
    assign hz.flush_de       = w_de.flush;
    assign hz.flush_em       = w_flush_em;
    assign hz.bubble_de      = w_de.bubble;
    assign hz.redirect_take  = w_redirect_take;
    assign hz.perf_stall_cnt = r_stall_cnt;
    assign hz.perf_flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a single-cycle vector table followed by
// hand-written multi-cycle sequences. Counters use a narrow width to reach saturation.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int PERF_W = 4;

    typedef struct packed {
        logic              rstN;
        logic              imem;
        logic              dmem;
        logic              dValid;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              dSer;
        logic              eValid;
        logic              mValid;
        logic              wValid;
        logic              eLoad;
        logic [REG_AW-1:0] eDst;
        logic              eRedir;
        logic              eMulti;
    } stim_t;

    // Expected bits: {stall_pc,fd,de,em,mw, flush_fd,de,em, bubble_de, redirect_take}
    typedef struct {
        string      name;
        stim_t      s;
        logic [9:0] e;
    } vec_t;

    localparam logic [9:0] E_NONE   = 10'b00000_000_0_0;
    localparam logic [9:0] E_RESET  = 10'b00000_111_0_0;
    localparam logic [9:0] E_BUBBLE = 10'b11000_000_1_0;
    localparam logic [9:0] E_MEM    = 10'b11111_000_0_0;
    localparam logic [9:0] E_MULTI  = 10'b11100_001_0_0;
    localparam logic [9:0] E_REDIR  = 10'b00000_110_0_1;
    localparam logic [9:0] E_IMEM   = 10'b10000_100_0_0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_AW(REG_AW), .PERF_W(PERF_W)) hz ();

    pipe_hazard_ctrl #(.REG_AW(REG_AW), .PERF_W(PERF_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    function automatic stim_t idle();
        stim_t s = '0;
        s.rstN = 1'b1;
        return s;
    endfunction

    function automatic stim_t loadUse(input logic [REG_AW-1:0] dst, rs1, rs2);
        stim_t s = idle();
        s.dValid = 1'b1;
        s.eValid = 1'b1;
        s.eLoad  = 1'b1;
        s.eDst   = dst;
        s.rs1    = rs1;
        s.rs2    = rs2;
        return s;
    endfunction

    function automatic stim_t serial(input logic ev, mv, wv);
        stim_t s = idle();
        s.dValid = 1'b1;
        s.dSer   = 1'b1;
        s.eValid = ev;
        s.mValid = mv;
        s.wValid = wv;
        return s;
    endfunction

    task automatic addVec(input string name, input stim_t s, input logic [9:0] e);
        vec_t v;
        v.name = name;
        v.s    = s;
        v.e    = e;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input stim_t s);
        @(negedge clk);
        reset           = s.rstN;
        hz.imem_busy    = s.imem;
        hz.dmem_busy    = s.dmem;
        hz.d_valid      = s.dValid;
        hz.d_rs1        = s.rs1;
        hz.d_rs2        = s.rs2;
        hz.d_serialize  = s.dSer;
        hz.e_valid      = s.eValid;
        hz.m_valid      = s.mValid;
        hz.w_valid      = s.wValid;
        hz.e_is_load    = s.eLoad;
        hz.e_dst        = s.eDst;
        hz.e_redirect   = s.eRedir;
        hz.e_multi_busy = s.eMulti;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [9:0] exp);
        logic [9:0] act;
        act = {hz.stall_pc, hz.stall_fd, hz.stall_de, hz.stall_em, hz.stall_mw,
               hz.flush_fd, hz.flush_de, hz.flush_em, hz.bubble_de, hz.redirect_take};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkCount(input string name, input logic [PERF_W-1:0] act, input logic [PERF_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input string name, input stim_t s, input logic [9:0] e);
        applyStimulus(s);
        checkOutput(name, e);
    endtask

    task automatic doReset(input string tag);
        stim_t s = idle();
        s.rstN = 1'b0;
        step({tag, "_rst0"}, s, E_RESET);
        step({tag, "_rst1"}, s, E_RESET);
        checkCount({tag, "_rst_stallcnt"}, hz.perf_stall_cnt, '0);
        checkCount({tag, "_rst_flushcnt"}, hz.perf_flush_cnt, '0);
    endtask

    initial begin
        stim_t s;

        applyStimulus(idle());

        // Single-cycle vectors, applied back to back in order.
        s = idle(); s.rstN = 1'b0;            addVec("reset_outputs", s, E_RESET);
        addVec("idle", idle(), E_NONE);
        addVec("loaduse_rs2", loadUse(5'd5, 5'd0, 5'd5), E_BUBBLE);
        addVec("loaduse_once", loadUse(5'd5, 5'd0, 5'd5), E_NONE);
        addVec("loaduse_x0", loadUse(5'd0, 5'd0, 5'd0), E_NONE);
        addVec("loaduse_rs1", loadUse(5'd7, 5'd7, 5'd3), E_BUBBLE);
        addVec("idle2", idle(), E_NONE);
        s = loadUse(5'd7, 5'd7, 5'd3); s.eLoad = 1'b0;  addVec("alu_no_hazard", s, E_NONE);
        s = idle(); s.imem = 1'b1;            addVec("imem_alone", s, E_IMEM);
        s = idle(); s.eRedir = 1'b1;          addVec("redirect", s, E_REDIR);
        s = loadUse(5'd4, 5'd4, 5'd0); s.dmem = 1'b1;   addVec("dmem_over_lu", s, E_MEM);
        s = idle(); s.eMulti = 1'b1;          addVec("multi_alone", s, E_MULTI);
        addVec("serialize", serial(1'b0, 1'b1, 1'b0), E_BUBBLE);
        addVec("serialize_release", serial(1'b0, 1'b0, 1'b0), E_NONE);
        s = loadUse(5'd9, 5'd0, 5'd9); s.imem = 1'b1;   addVec("lu_with_imem", s, E_BUBBLE);
        s = idle(); s.rstN = 1'b0; s.dmem = 1'b1;       addVec("reset_over_dmem", s, E_RESET);

        foreach (vecs[i]) step(vecs[i].name, vecs[i].s, vecs[i].e);

        // Redirect while instruction memory is busy for three cycles.
        doReset("imemRedir");
        s = idle(); s.imem = 1'b1; s.eRedir = 1'b1;
        step("imemRedir_c1", s, E_REDIR);
        s.eRedir = 1'b0;
        step("imemRedir_c2", s, E_IMEM);
        step("imemRedir_c3", s, E_IMEM);
        step("imemRedir_c4", idle(), E_NONE);

        // Redirect lost under a 4-cycle data memory wait.
        doReset("dmemRedir");
        for (int c = 1; c <= 4; c++) begin
            s = idle(); s.dmem = 1'b1; s.eRedir = (c == 2);
            step($sformatf("dmemRedir_c%0d", c), s, E_MEM);
        end
        step("dmemRedir_c5", idle(), E_REDIR);
        step("dmemRedir_c6", idle(), E_NONE);
        checkCount("dmemRedir_stallcnt", hz.perf_stall_cnt, 4'd4);
        checkCount("dmemRedir_flushcnt", hz.perf_flush_cnt, 4'd1);

        // Redirect lost under a multi-cycle execute.
        doReset("multiRedir");
        s = idle(); s.eMulti = 1'b1; s.eRedir = 1'b1;
        step("multiRedir_c1", s, E_MULTI);
        s.eRedir = 1'b0;
        step("multiRedir_c2", s, E_MULTI);
        step("multiRedir_c3", idle(), E_REDIR);
        step("multiRedir_c4", idle(), E_NONE);

        // Serialize drains E, M, W one stage per cycle, then D is released.
        doReset("drain");
        step("drain_c1", serial(1'b1, 1'b1, 1'b1), E_BUBBLE);
        step("drain_c2", serial(1'b0, 1'b1, 1'b1), E_BUBBLE);
        step("drain_c3", serial(1'b0, 1'b0, 1'b1), E_BUBBLE);
        step("drain_release", serial(1'b0, 1'b0, 1'b0), E_NONE);

        // Multi-cycle execute beats a simultaneous load-use, which follows for one cycle.
        doReset("multiLu");
        for (int c = 1; c <= 10; c++) begin
            s = loadUse(5'd6, 5'd6, 5'd1); s.eMulti = 1'b1;
            step($sformatf("multiLu_c%0d", c), s, E_MULTI);
        end
        step("multiLu_bubble", loadUse(5'd6, 5'd6, 5'd1), E_BUBBLE);
        step("multiLu_after", loadUse(5'd6, 5'd6, 5'd1), E_NONE);
        checkCount("multiLu_stallcnt", hz.perf_stall_cnt, 4'd11);

        // Stall counter saturates at all-ones.
        s = idle(); s.dmem = 1'b1;
        for (int c = 1; c <= 20; c++) applyStimulus(s);
        step("sat_idle", idle(), E_NONE);
        checkCount("sat_stallcnt", hz.perf_stall_cnt, 4'hF);
        checkCount("sat_flushcnt", hz.perf_flush_cnt, 4'd0);

        // Reset asserted in the middle of a drain.
        doReset("rstDrain");
        step("rstDrain_c1", serial(1'b1, 1'b1, 1'b0), E_BUBBLE);
        s = serial(1'b1, 1'b1, 1'b0); s.rstN = 1'b0;
        step("rstDrain_r1", s, E_RESET);
        step("rstDrain_r2", s, E_RESET);
        checkCount("rstDrain_stallcnt", hz.perf_stall_cnt, 4'd0);
        checkCount("rstDrain_flushcnt", hz.perf_flush_cnt, 4'd0);
        step("rstDrain_run", idle(), E_NONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/bubble sequencer for the 5-stage pipeline. It drives the control inputs of the F/D/E/M/W pipeline registers (hold, clear, bubble) from hazard sources: load-use, branch redirect, memory wait, multi-cycle execute and serializing instructions (CSR/fence). Its per-register outputs match the pipeline-register priority: flush over stall over bubble.

Parameters:
REG_AW, 5, architectural register index width
PERF_W, 32, width of stall/flush performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (0 = reset)
imem_busy  in  1  fetch waiting on instruction memory
dmem_busy  in  1  M stage waiting on data memory
d_valid  in  1  D holds a real instruction
d_rs1, d_rs2  in  REG_AW each  D source registers (0 = unused)
d_serialize  in  1  D instruction is CSR/fence (must execute alone)
e_valid, m_valid, w_valid  in  1 each  stage holds a real instruction
e_is_load  in  1  E instruction is a load
e_dst  in  REG_AW  E destination register
e_redirect  in  1  E resolved taken branch/jump (one-cycle pulse)
e_multi_busy  in  1  E multi-cycle unit not done
stall_pc, stall_fd, stall_de, stall_em, stall_mw  out  1 each  hold register
flush_fd, flush_de, flush_em  out  1 each  clear register
bubble_de  out  1  insert NOP into D/E
redirect_take  out  1  PC mux selects redirect target this cycle
perf_stall_cnt, perf_flush_cnt  out  PERF_W each  saturating event counters

Behaviour:
- State register, 4 states: RUN, MEM_WAIT, MULTI, DRAIN. Outputs are combinational from state and inputs. State, pending_redirect and counters are registered.
- Reset (reset==0 at clk edge): state=RUN, pending_redirect=0, counters=0. While reset==0 the outputs are flush_fd=flush_de=flush_em=1, all stalls=0, bubble_de=0, redirect_take=0.
- Priority each cycle, highest first: dmem_busy > e_multi_busy > redirect > serialize > load-use.
- dmem_busy=1: all five stalls=1, no flush, no bubble. State goes to MEM_WAIT and returns to RUN on the first cycle dmem_busy=0.
- e_multi_busy=1 (no dmem_busy): stall_pc/fd/de=1. flush_em=1 so a bubble enters M, while M/W continue. State is MULTI until e_multi_busy=0.
- Redirect: e_redirect=1 with no higher event gives flush_fd=flush_de=1 and redirect_take=1 in the same cycle. If the redirect coincides with imem_busy, set pending_redirect; flush_fd stays asserted each cycle until imem_busy=0, then pending_redirect clears. If e_redirect is lost under dmem_busy/multi, it is latched into pending_redirect and issued on the first free cycle. redirect_take fires exactly once per redirect.
- Serialize: d_valid and d_serialize, and any of e/m/w_valid is set: stall_pc/fd=1, bubble_de=1, state=DRAIN. Leave DRAIN when e/m/w_valid are all 0 and the D instruction is released, with no bubble that cycle. A redirect in DRAIN aborts the drain (flush wins) and returns to RUN.
- Load-use: e_is_load and e_valid and e_dst!=0 and (e_dst==d_rs1 or e_dst==d_rs2) with d_valid. Response is stall_pc/fd=1 and bubble_de=1 for exactly one cycle.
- imem_busy alone: stall_pc=1 and flush_fd=1, so an empty slot flows into D. Later stages continue.
- Never assert stall_x and flush_x on the same register in one cycle.
- perf_stall_cnt increments on any cycle with stall_pc=1. perf_flush_cnt increments on every cycle with flush_de=1 after reset. Both saturate at all-ones.

Decomposition:
- Shared package (common): enum hz_state_t {RUN, MEM_WAIT, MULTI, DRAIN} and typedef pipe_ctl_t {stall, flush, bubble}. Regs then take a pipe_ctl_t per stage.
- Sub-module: hz_loaduse_cmp (combinational dst/src compare with x0 masking), instantiated once.

Test Plan:
- Load-use: e_is_load=1, e_dst=5, d_rs2=5 -> one cycle of stall_pc=stall_fd=bubble_de=1, then all 0. With e_dst=0 -> no stall.
- Redirect during imem_busy=1 for 3 cycles -> redirect_take=1 once in the first cycle, flush_fd=1 for all 3 cycles, pending_redirect clears on the 4th.
- dmem_busy for 4 cycles with e_redirect pulsed in cycle 2 -> all stalls=1 for 4 cycles, then redirect_take=flush_fd=flush_de=1 in cycle 5, perf_stall_cnt=4.
- d_serialize with e/m/w_valid set, draining over 3 cycles -> DRAIN for 3 cycles with bubble_de=1, then release with no bubble.
- e_multi_busy 10 cycles with a simultaneous load-use -> MULTI wins, stall_de=1 and flush_em=1 for 10 cycles, then the load-use bubble for 1 cycle.
- reset=0 asserted mid-DRAIN -> next cycle state=RUN, counters=0, flush_fd/de/em=1 while reset stays low.
